// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver: raw pins to toggle-strobed {toggle,pressed,ext,code}.
// Define PS2_TYPEMATIC_FILTER_EN to drop repeated makes of a held key.
module ps2_key_decoder #(
  parameter int CLK_FREQ_HZ = 24000000,
  parameter int TIMEOUT_US  = 200,
  parameter int FILTER_LEN  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int LIMIT = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(LIMIT + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(LIMIT - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic          filt_q;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      filt_q   <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  logic fall;
  logic din;

  assign fall = filt_q & ~filt_clk;
  assign din  = dat_sync[1];

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          frame_ok;
  logic          stop_ok;
  logic          err;

  assign timeout  = (state != S_IDLE) && !fall && (to_cnt == TO_MAX);
  assign frame_ok = din && (^{shift, par});
  assign stop_ok  = fall && (state == S_STOP) && frame_ok;
  assign err      = timeout
                  | (fall && (state == S_IDLE) && din)
                  | (fall && (state == S_STOP) && !frame_ok);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (fall || state == S_IDLE) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      if (timeout) begin
        state <= S_IDLE;
      end else if (fall) begin
        unique case (state)
          S_IDLE: begin
            if (!din) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift   <= {din, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= din;
            state <= S_STOP;
          end
          S_STOP: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic       ext;
  logic       rel;
  logic [2:0] skip_cnt;
  logic       is_resp;

  assign is_resp = (shift == 8'h00) || (shift == 8'hAA)
                || (shift == 8'hEE) || (shift == 8'hFA)
                || (shift == 8'hFC) || (shift == 8'hFE)
                || (shift == 8'hFF);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_key;
  logic       held;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ps2_key  <= '0;
      ext      <= 1'b0;
      rel      <= 1'b0;
      skip_cnt <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_key <= '0;
      held     <= 1'b0;
`endif
    end else if (err) begin
      ext      <= 1'b0;
      rel      <= 1'b0;
      skip_cnt <= '0;
    end else if (stop_ok) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 1'b1;
      end else if (shift == 8'hE1) begin
        // pause sends E1 plus seven more bytes and has no break
        skip_cnt <= 3'd7;
        ext      <= 1'b0;
        rel      <= 1'b0;
      end else if (shift == 8'hE0) begin
        ext <= 1'b1;
      end else if (shift == 8'hF0) begin
        rel <= 1'b1;
      end else if (ext || rel || !is_resp) begin
        ext <= 1'b0;
        rel <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (rel) begin
          held    <= 1'b0;
          ps2_key <= {~ps2_key[10], 1'b0, ext, shift};
        end else if (!(held && last_key == {ext, shift})) begin
          held     <= 1'b1;
          last_key <= {ext, shift};
          ps2_key  <= {~ps2_key[10], 1'b1, ext, shift};
        end
`else
        ps2_key <= {~ps2_key[10], ~rel, ext, shift};
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder driving bit-level PS/2 frames.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int H = 20;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int n_checks = 0;
  int n_pass = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int err_w = 0;
  logic [10:0] exp_q[$];
  logic [10:0] model_key = '0;
  logic [10:0] prev_key = '0;

  ps2_key_decoder #(
    .CLK_FREQ_HZ(1000000),
    .TIMEOUT_US(200),
    .FILTER_LEN(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key(ps2_key),
    .frame_err(frame_err)
  );

  always #500 CLK = ~CLK;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      prev_key = ps2_key;
      err_w = 0;
    end else begin
      if (ps2_key !== prev_key) begin
        ev_cnt++;
        if (exp_q.size() == 0)
          check("spurious_event", int'(ps2_key), int'(prev_key));
        else
          check("event", int'(ps2_key), int'(exp_q.pop_front()));
        prev_key = ps2_key;
      end
      if (frame_err) begin
        if (err_w == 0) err_cnt++;
        err_w++;
      end else if (err_w != 0) begin
        check("err_width", err_w, 1);
        err_w = 0;
      end
    end
  end

  task automatic expect_ev(input bit pressed, input bit ext,
                           input logic [7:0] code);
    model_key = {~model_key[10], pressed, ext, code};
    exp_q.push_back(model_key);
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    @(negedge CLK);
    ps2_data = b;
    if (glitch) begin
      repeat (5) @(negedge CLK);
      ps2_clk = 1'b0;
      repeat (3) @(negedge CLK);
      ps2_clk = 1'b1;
      repeat (H - 8) @(negedge CLK);
    end else begin
      repeat (H) @(negedge CLK);
    end
    ps2_clk = 1'b0;
    repeat (H) @(negedge CLK);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && i == 3);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(~bad_stop, 1'b0);
    ps2_data = 1'b1;
    repeat (3 * H) @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] tail;
    int base;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                  8'hF0, 8'h14, 8'hF0, 8'h77};
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_key", int'(ps2_key), 0);
    check("rst_err", int'(frame_err), 0);

    expect_ev(1'b1, 1'b0, 8'h1C);
    send(8'h1C);
    check("make_1c_q", exp_q.size(), 0);
    check("make_1c_key", int'(ps2_key), 'h61C);
    check("make_1c_err", err_cnt, 0);

    expect_ev(1'b0, 1'b1, 8'h75);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ext_rel_q", exp_q.size(), 0);
    check("ext_rel_key", int'(ps2_key), 'h175);
    check("ext_rel_err", err_cnt, 0);

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("bad_par_err", err_cnt, 1);
    check("bad_par_hold", int'(ps2_key), int'(model_key));
    expect_ev(1'b1, 1'b0, 8'h29);
    send(8'h29);
    check("after_par_q", exp_q.size(), 0);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("bad_stop_err", err_cnt, 2);

    send(8'hE0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (250) @(negedge CLK);
    check("timeout_err", err_cnt, 3);
    expect_ev(1'b1, 1'b0, 8'h16);
    send(8'h16);
    check("timeout_q", exp_q.size(), 0);
    check("timeout_err_once", err_cnt, 3);

    base = ev_cnt;
    foreach (pause_seq[i]) send(pause_seq[i]);
    check("pause_no_ev", ev_cnt - base, 0);
    expect_ev(1'b1, 1'b0, 8'h05);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1);
    check("pause_glitch_q", exp_q.size(), 0);
    check("pause_ev", ev_cnt - base, 1);
    check("glitch_err", err_cnt, 3);

    base = ev_cnt;
    send(8'hFA);
    send(8'hAA);
    check("resp_drop", ev_cnt - base, 0);

    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    model_key = '0;
    check("rst_mid_key", int'(ps2_key), 0);
    base = err_cnt;
    tail = 8'b0000_0111;
    for (int i = 0; i < 6; i++) send_bit(tail[i], 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (250) @(negedge CLK);
    check("rst_mid_errs", err_cnt - base, 4);
    expect_ev(1'b1, 1'b0, 8'h29);
    send(8'h29);
    check("rst_mid_q", exp_q.size(), 0);
    check("rst_mid_key2", int'(ps2_key), 'h629);

    base = ev_cnt;
`ifdef PS2_TYPEMATIC_FILTER_EN
    expect_ev(1'b1, 1'b0, 8'h75);
    for (int i = 0; i < 3; i++) send(8'h75);
    expect_ev(1'b0, 1'b0, 8'h75);
    send(8'hF0);
    send(8'h75);
    check("typematic_ev", ev_cnt - base, 2);
`else
    for (int i = 0; i < 3; i++) begin
      expect_ev(1'b1, 1'b0, 8'h75);
      send(8'h75);
    end
    expect_ev(1'b0, 1'b0, 8'h75);
    send(8'hF0);
    send(8'h75);
    check("typematic_ev", ev_cnt - base, 4);
`endif
    check("final_q", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
